// File: rtl/lvds_rx_decoder.sv
// lvds_rx_decoder: LVDS receive-side word alignment and VESA 24-bit decode.
// Takes 7-bit words per lane from the deserializer, drives a bitslip handshake
// until the clock lane matches CLK_PATTERN, then decodes RGB/DE/HS/VS and
// regenerates x/y pixel coordinates.
// Optional build macro LVDS_RX_STATS_EN adds o_err_count and o_line_count.
module lvds_rx_decoder #(
   parameter int unsigned SLIP_WAIT   = 4,
   parameter int unsigned LOCK_COUNT  = 16,
   parameter int unsigned LOSS_COUNT  = 4,
   parameter logic [6:0]  CLK_PATTERN = 7'b1100011
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic [34:0] i_words,
   output logic        o_bitslip,
   output logic        o_locked,
   output logic [23:0] o_color,
   output logic        o_de,
   output logic        o_hs,
   output logic        o_vs,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
`ifdef LVDS_RX_STATS_EN
   output logic [15:0] o_err_count,
   output logic [11:0] o_line_count,
`endif
   output logic        o_frame_start
);

   localparam int unsigned WAIT_W  = $clog2(SLIP_WAIT + 1);
   localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LOSS_W  = $clog2(LOSS_COUNT + 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_COUNT - 1);

   typedef enum logic [2:0] {
      S_SEARCH,
      S_SLIP,
      S_WAIT,
      S_VERIFY,
      S_LOCKED
   } state_t;

   state_t               state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic [LOSS_W-1:0]    loss_q, loss_d;
   logic                 clk_match;
   logic                 lock_d;

   logic [7:0]           red, green, blue;
   logic                 de_in, hs_in, vs_in;
   logic                 de_rise, de_fall, vs_rise;
   logic [11:0]          y_d;
   logic                 frame_start_d;
   logic                 vs_seen_q;

   // lane3 bit 6 is a reserved bit in the VESA mapping
   logic                 unused_res;
   assign unused_res = i_words[34];

   assign clk_match = (i_words[6:0] == CLK_PATTERN);
   assign lock_d    = (state_d == S_LOCKED);
   assign o_locked  = (state_q == S_LOCKED);

   // alignment FSM state and counter registers
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q <= S_SEARCH;
         wait_q  <= '0;
         match_q <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         match_q <= match_d;
         loss_q  <= loss_d;
      end
   end

   // alignment FSM next-state, counters and bitslip request
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      match_d   = match_q;
      loss_d    = loss_q;
      o_bitslip = 1'b0;
      unique case (state_q)
         S_SEARCH: begin
            if (clk_match) begin
               state_d = S_VERIFY;
               match_d = MATCH_W'(1);
            end else begin
               state_d = S_SLIP;
            end
         end
         S_SLIP: begin
            o_bitslip = 1'b1;
            wait_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_SEARCH;
            else                     wait_d  = wait_q + WAIT_W'(1);
         end
         S_VERIFY: begin
            if (!clk_match) begin
               state_d = S_SLIP;
            end else if (match_q == MATCH_LAST) begin
               state_d = S_LOCKED;
               loss_d  = '0;
            end else begin
               match_d = match_q + MATCH_W'(1);
            end
         end
         S_LOCKED: begin
            if (clk_match)              loss_d  = '0;
            else if (loss_q == LOSS_LAST) state_d = S_SEARCH;
            else                        loss_d  = loss_q + LOSS_W'(1);
         end
         default: state_d = S_SEARCH;
      endcase
   end

   // VESA 24-bit field extraction and x/y edge detection against registered outputs
   always_comb begin
      red     = {i_words[29:28], i_words[12:7]};
      green   = {i_words[31:30], i_words[18:14], i_words[13]};
      blue    = {i_words[33:32], i_words[24:21], i_words[20:19]};
      de_in   = i_words[27];
      vs_in   = i_words[26];
      hs_in   = i_words[25];
      de_rise = de_in & ~o_de;
      de_fall = ~de_in & o_de;
      vs_rise = vs_in & ~o_vs;
      y_d     = vs_rise ? '0 : (de_fall ? o_y + 12'd1 : o_y);
      frame_start_d = de_rise & (vs_seen_q | vs_rise) & (y_d == '0);
   end

   // decoded output and pixel tracking registers; keyed on next lock state so
   // o_locked, the data outputs and the tracking reset all change on one edge
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_color       <= '0;
         o_de          <= 1'b0;
         o_hs          <= 1'b0;
         o_vs          <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
         vs_seen_q     <= 1'b0;
      end else if (!lock_d) begin
         o_color       <= '0;
         o_de          <= 1'b0;
         o_hs          <= 1'b0;
         o_vs          <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
         vs_seen_q     <= 1'b0;
      end else begin
         o_color       <= {red, green, blue};
         o_de          <= de_in;
         o_hs          <= hs_in;
         o_vs          <= vs_in;
         if (de_in) o_x <= de_rise ? '0 : o_x + 12'd1;
         o_y           <= y_d;
         o_frame_start <= frame_start_d;
         vs_seen_q     <= frame_start_d ? 1'b0 : (vs_seen_q | vs_rise);
      end
   end

`ifdef LVDS_RX_STATS_EN
   logic [11:0] line_acc_q;

   // saturating clock-lane error count while locked, cleared only by reset
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn)                                           o_err_count <= '0;
      else if (o_locked && !clk_match && (o_err_count != '1)) o_err_count <= o_err_count + 16'd1;
   end

   // lines per frame: accumulate DE falls, latch on VS rise (a coincident fall belongs to the old frame)
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         line_acc_q   <= '0;
         o_line_count <= '0;
      end else if (!lock_d) begin
         line_acc_q   <= '0;
      end else if (vs_rise) begin
         o_line_count <= line_acc_q + 12'(de_fall);
         line_acc_q   <= '0;
      end else if (de_fall) begin
         line_acc_q   <= line_acc_q + 12'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lvds_rx_decoder.sv
// tb_lvds_rx_decoder: directed bench with a pixel scoreboard for lvds_rx_decoder.
// A deserializer model rotates all lanes and undoes one bit per o_bitslip pulse.
module tb_lvds_rx_decoder;

   localparam int unsigned SLIP_WAIT = 4;
   localparam logic [6:0]  PAT       = 7'b1100011;

   logic        clk = 1'b0;
   logic        resetn;
   logic [34:0] words;
   logic        o_bitslip, o_locked, o_de, o_hs, o_vs, o_frame_start;
   logic [23:0] o_color;
   logic [11:0] o_x, o_y;
`ifdef LVDS_RX_STATS_EN
   logic [15:0] o_err_count;
   logic [11:0] o_line_count;
`endif

   logic [27:0] data;
   logic [6:0]  clkw;
   int          rot;
   int          cyc, nslip, last_slip;
   int          total = 0;
   int          bad = 0;
   logic [48:0] sb[$];
   logic [48:0] exp_v;

   always #5 clk = ~clk;

   lvds_rx_decoder #(.SLIP_WAIT(SLIP_WAIT), .LOCK_COUNT(16), .LOSS_COUNT(4), .CLK_PATTERN(PAT)) dut (
      .i_clk(clk), .i_resetn(resetn), .i_words(words),
      .o_bitslip(o_bitslip), .o_locked(o_locked), .o_color(o_color),
      .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_x(o_x), .o_y(o_y),
`ifdef LVDS_RX_STATS_EN
      .o_err_count(o_err_count), .o_line_count(o_line_count),
`endif
      .o_frame_start(o_frame_start)
   );

   function automatic logic [6:0] rotw(input logic [6:0] w, input int n);
      logic [6:0] t;
      t = w;
      for (int i = 0; i < n; i++) t = {t[5:0], t[6]};
      return t;
   endfunction

   // VESA 24-bit encoder, bit 6 first: {l3,l2,l1,l0}
   function automatic logic [27:0] enc(input logic [23:0] c, input logic de, input logic hs, input logic vs);
      logic [7:0] r, g, b;
      logic [6:0] l0, l1, l2, l3;
      r  = c[23:16];
      g  = c[15:8];
      b  = c[7:0];
      l0 = {g[0], r[5], r[4], r[3], r[2], r[1], r[0]};
      l1 = {b[1], b[0], g[5], g[4], g[3], g[2], g[1]};
      l2 = {de, vs, hs, b[5], b[4], b[3], b[2]};
      l3 = {1'b0, b[7], b[6], g[7], g[6], r[7], r[6]};
      return {l3, l2, l1, l0};
   endfunction

   assign words = {rotw(data[27:21], rot), rotw(data[20:14], rot), rotw(data[13:7], rot),
                   rotw(data[6:0], rot), rotw(clkw, rot)};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // one clock: sample o_bitslip, pass the edge, then apply the deserializer rotation
   task automatic tick();
      logic slip;
      @(negedge clk);
      slip = o_bitslip;
      @(posedge clk);
      #1;
      cyc++;
      if (slip) begin
         if (nslip > 0) check("slip_gap_ok", 64'((cyc - last_slip) >= int'(SLIP_WAIT + 2)), 64'd1);
         nslip++;
         last_slip = cyc;
         if (rot > 0) rot--;
      end
   endtask

   task automatic idle(input int n, input logic vs);
      data = enc(24'h0, 1'b0, 1'b0, vs);
      repeat (n) tick();
   endtask

   task automatic pix(input logic [23:0] c, input logic [11:0] x, input logic [11:0] y, input logic fs);
      data = enc(c, 1'b1, 1'b0, 1'b0);
      sb.push_back({c, x, y, fs});
      tick();
   endtask

   task automatic wait_lock(input int maxc, output int n);
      n = 0;
      while (!o_locked && n < maxc) begin
         tick();
         n++;
      end
   endtask

   // scoreboard monitor: every active pixel presented by the DUT is checked against the queue
   always @(negedge clk) begin
      if (resetn && o_de) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pixel: got color=%h x=%0d y=%0d fs=%0b expected none",
                     o_color, o_x, o_y, o_frame_start);
         end else begin
            exp_v = sb.pop_front();
            if ({o_color, o_x, o_y, o_frame_start} !== exp_v) begin
               bad++;
               $display("FAIL pixel: got color=%h x=%0d y=%0d fs=%0b expected color=%h x=%0d y=%0d fs=%0b",
                        o_color, o_x, o_y, o_frame_start, exp_v[48:25], exp_v[24:13], exp_v[12:1], exp_v[0]);
            end
         end
      end
   end

   initial begin
      int n;
      resetn = 1'b0;
      clkw = PAT;
      data = '0;
      rot = 0;
      cyc = 0;
      nslip = 0;
      last_slip = 0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {o_locked, o_bitslip, o_color, o_de, o_hs, o_vs, o_x, o_y, o_frame_start}, '0);

      // aligned input: 16 matching words to lock, no slips
      resetn = 1'b1;
      wait_lock(40, n);
      check("lock_latency_aligned", n, 16);
      check("no_slip_aligned", nslip, 0);

      // single pixel, one-cycle latency
      data = enc(24'hA53CF0, 1'b1, 1'b0, 1'b0);
      sb.push_back({24'hA53CF0, 12'd0, 12'd0, 1'b0});
      tick();
      check("pixel_latency", {o_de, o_color}, {1'b1, 24'hA53CF0});
      idle(2, 1'b0);

      // frame: VS pulse then 4 lines x 8 pixels
      idle(1, 1'b1);
      idle(2, 1'b0);
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < 8; p++)
            pix({4'(l), 4'(p), 16'h55AA}, 12'(p), 12'(l), (l == 0 && p == 0));
         idle(3, 1'b0);
      end

      // x wrap at 4095 on a long line (y = 4 after the frame)
      for (int i = 0; i < 4097; i++) pix(24'h123456, 12'(i), 12'd4, 1'b0);
      // VS rise on the same cycle as DE fall: y must clear, next line starts a frame
      data = enc(24'h0, 1'b0, 1'b0, 1'b1);
      tick();
      pix(24'h00FF00, 12'd0, 12'd0, 1'b1);
      idle(2, 1'b0);

      // loss of lock: 3-bad burst survives, 4 consecutive drop lock
      data = enc(24'h5A5A5A, 1'b0, 1'b1, 1'b0);
      repeat (2) tick();
      check("locked_data_hs", {o_locked, o_hs, o_color}, {1'b1, 1'b1, 24'h5A5A5A});
      clkw = 7'h00;
      repeat (3) tick();
      check("lock_after_3_bad", o_locked, 1);
      clkw = PAT;
      tick();
      clkw = 7'h00;
      repeat (3) tick();
      check("lock_after_3_bad_again", o_locked, 1);
      tick();
      check("lock_drop_outputs", {o_locked, o_hs, o_de, o_color}, '0);
      clkw = PAT;
      wait_lock(40, n);
      check("relock_latency", n, 16);
      check("no_slip_relock", nslip, 0);
      pix(24'hABCDEF, 12'd0, 12'd0, 1'b0);
      idle(2, 1'b0);

      // rotated by 3 bits: exactly three slips then lock
      resetn = 1'b0;
      rot = 3;
      repeat (2) tick();
      resetn = 1'b1;
      wait_lock(200, n);
      check("slip_count", nslip, 3);
      check("locked_after_slips", o_locked, 1);
      check("no_rotation_left", rot, 0);

      // asynchronous reset mid-frame
      idle(1, 1'b1);
      pix(24'h111111, 12'd0, 12'd0, 1'b1);
      pix(24'h222222, 12'd1, 12'd0, 1'b0);
      data = enc(24'h333333, 1'b1, 1'b0, 1'b0);
      tick();
      resetn = 1'b0;
      #1;
      check("midframe_reset", {o_locked, o_bitslip, o_color, o_de, o_hs, o_vs, o_x, o_y, o_frame_start}, '0);
      data = '0;
      repeat (2) tick();
      resetn = 1'b1;
      check("unlocked_after_release", o_locked, 0);
      wait_lock(40, n);
      check("relock_after_reset", n, 16);

      idle(2, 1'b0);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
